// File: rtl/serial_mem_bridge.sv
// Byte-serial bridge between cpu_core and on-chip instruction/data memories.
// Optional out-of-range address checking is enabled by defining SMB_RANGE_CHECK_EN.
module serial_mem_bridge #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    out_bus,
  input  logic          bus_pc,
  input  logic          bus_mar,
  input  logic          bus_mdr,
  input  logic          halt,
  output logic [7:0]    in_bus,
  output logic          ard_data_ready,
  output logic          ard_receive_ready,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic [AW-1:0] dbg_addr,
  output logic [15:0]   dbg_data
`ifdef SMB_RANGE_CHECK_EN
  ,
  output logic          range_err
`endif
);

  // Opcode-class encodings from the core package (low nibble of an instruction word).
  localparam logic [3:0] ITypeCode = 4'h2;
  localparam logic [3:0] MTypeCode = 4'h3;

  typedef enum logic [3:0] {
    StIdle, StAHi, StILo, StIHi, StXLo, StXHi,
    StDLo, StDHi, StWLo, StWHi, StTurn, StHalted
  } state_e;

  state_e          state_q, state_d;
  logic [15:0]     addr_q;
  logic            fetch_q;
  logic [7:0]      st_lo_q;
  logic [15:0]     instr_mem [DEPTH];
  logic [15:0]     data_mem  [DEPTH];

  logic [15:0]     addr_cur;
  logic [AW-1:0]   idx, idx_nx;
  logic            oor;
  logic [15:0]     instr_w, instr_w2, data_w;
  logic [7:0]      in_bus_d;
  logic            dr_d, rr_d;

  // In A_HI the high address byte is still on out_bus; use it before it is latched.
  assign addr_cur = (state_q == StAHi) ? {out_bus, addr_q[7:0]} : addr_q;
  assign idx      = addr_cur[AW-1:0];
  assign idx_nx   = idx + AW'(1);

`ifdef SMB_RANGE_CHECK_EN
  assign oor = (addr_cur >> AW) != 16'd0;
`else
  assign oor = 1'b0;
  logic unused_addr;
  assign unused_addr = ^addr_cur[15:AW];
`endif

  assign instr_w  = oor ? 16'hFFFF : instr_mem[idx];
  assign instr_w2 = oor ? 16'hFFFF : instr_mem[idx_nx];
  assign data_w   = oor ? 16'hFFFF : data_mem[idx];
  assign dbg_data = data_mem[dbg_addr];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (halt)                   state_d = StHalted;
        else if (bus_pc || bus_mar) state_d = StAHi;
      end
      StAHi:    state_d = fetch_q ? StILo : (bus_mdr ? StWLo : StDLo);
      StILo:    state_d = StIHi;
      StIHi:    state_d = (instr_w[3:0] == ITypeCode || instr_w[3:0] == MTypeCode) ?
                          StXLo : StTurn;
      StXLo:    state_d = StXHi;
      StXHi:    state_d = StTurn;
      StDLo:    state_d = StDHi;
      StDHi:    state_d = StTurn;
      StWLo:    state_d = StWHi;
      StWHi:    state_d = StTurn;
      StTurn:   state_d = StIdle;
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    in_bus_d = 8'h00;
    dr_d     = 1'b0;
    rr_d     = 1'b0;
    case (state_d)
      StIdle: rr_d = 1'b1;
      StILo:  begin dr_d = 1'b1; in_bus_d = instr_w[7:0];   end
      StIHi:  begin dr_d = 1'b1; in_bus_d = instr_w[15:8];  end
      StXLo:  begin dr_d = 1'b1; in_bus_d = instr_w2[7:0];  end
      StXHi:  begin dr_d = 1'b1; in_bus_d = instr_w2[15:8]; end
      StDLo:  begin dr_d = 1'b1; in_bus_d = data_w[7:0];    end
      StDHi:  begin dr_d = 1'b1; in_bus_d = data_w[15:8];   end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q           <= StIdle;
      in_bus            <= 8'h00;
      ard_data_ready    <= 1'b0;
      ard_receive_ready <= 1'b0;
      addr_q            <= 16'h0000;
      fetch_q           <= 1'b0;
      st_lo_q           <= 8'h00;
      for (int i = 0; i < int'(DEPTH); i++) data_mem[i] <= 16'h0000;
`ifdef SMB_RANGE_CHECK_EN
      range_err         <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      in_bus            <= in_bus_d;
      ard_data_ready    <= dr_d;
      ard_receive_ready <= rr_d;
      if (state_q == StIdle && !halt && (bus_pc || bus_mar)) begin
        addr_q[7:0] <= out_bus;
        fetch_q     <= bus_pc;
      end
      if (state_q == StAHi) addr_q[15:8] <= out_bus;
      if (state_q == StWLo) st_lo_q <= out_bus;
      if (state_q == StWHi && !oor) data_mem[idx] <= {out_bus, st_lo_q};
`ifdef SMB_RANGE_CHECK_EN
      if (state_q == StAHi && oor) range_err <= 1'b1;
`endif
    end
  end

  // Instruction memory survives reset; loads only land while the bridge is quiescent.
  always_ff @(posedge clk) begin
    if (prog_we && (state_q == StIdle || state_q == StHalted)) begin
      instr_mem[prog_addr] <= prog_data;
    end
  end

endmodule

// File: tb/tb_serial_mem_bridge.sv
// Directed bench for serial_mem_bridge: fetches, loads, stores, halt and reset abort.
module tb_serial_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  out_bus;
  logic        bus_pc, bus_mar, bus_mdr, halt;
  logic [7:0]  in_bus;
  logic        ard_data_ready, ard_receive_ready;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [15:0] prog_data;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
`ifdef SMB_RANGE_CHECK_EN
  logic        range_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_mem_bridge #(.DEPTH(16), .AW(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .out_bus           (out_bus),
    .bus_pc            (bus_pc),
    .bus_mar           (bus_mar),
    .bus_mdr           (bus_mdr),
    .halt              (halt),
    .in_bus            (in_bus),
    .ard_data_ready    (ard_data_ready),
    .ard_receive_ready (ard_receive_ready),
    .prog_we           (prog_we),
    .prog_addr         (prog_addr),
    .prog_data         (prog_data),
    .dbg_addr          (dbg_addr),
    .dbg_data          (dbg_data)
`ifdef SMB_RANGE_CHECK_EN
    ,
    .range_err         (range_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [3:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic peek(input logic [3:0] a, output logic [15:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  // Runs one request from IDLE; bytes are shifted in oldest-first, lat counts edges to ready.
  task automatic xact(input logic pc, input logic mar_too, input logic st,
                      input logic drop_prog, input logic [15:0] addr, input logic [15:0] wd,
                      output int lat, output int nb, output logic [31:0] bytes,
                      output int vio);
    lat = 0; nb = 0; bytes = 32'h0; vio = 0;
    bus_pc = pc; bus_mar = !pc || mar_too; out_bus = addr[7:0];
    step(); lat = 1;
    bus_pc = 1'b0; bus_mar = 1'b0; bus_mdr = st; out_bus = addr[15:8];
    if (drop_prog) begin prog_we = 1'b1; prog_addr = addr[3:0]; prog_data = 16'hFFFF; end
    step(); lat = 2;
    bus_mdr = 1'b0; prog_we = 1'b0;
    if (st) begin
      out_bus = wd[7:0];  step(); lat = 3;
      out_bus = wd[15:8]; step(); lat = 4;
      out_bus = 8'h00;
    end
    while (!ard_receive_ready && lat < 12) begin
      if (ard_data_ready) begin bytes = {bytes[23:0], in_bus}; nb++; end
      else if (in_bus != 8'h00) vio++;
      step(); lat++;
    end
  endtask

  int          lat, nb, vio, busy;
  logic [31:0] bytes;
  logic [15:0] d;

  initial begin
    rst = 1'b0; out_bus = 8'h00; bus_pc = 1'b0; bus_mar = 1'b0; bus_mdr = 1'b0; halt = 1'b0;
    prog_we = 1'b0; prog_addr = 4'h0; prog_data = 16'h0; dbg_addr = 4'h0;
    step(); step();
    check("rst_rr", {31'b0, ard_receive_ready}, 32'd0);
    check("rst_dr", {31'b0, ard_data_ready}, 32'd0);
    check("rst_inbus", {24'b0, in_bus}, 32'd0);
    rst = 1'b1;
    step();
    check("rel_rr", {31'b0, ard_receive_ready}, 32'd1);

    prog(4'd5, 16'h0A51); prog(4'd1, 16'h1232); prog(4'd2, 16'h0005);
    prog(4'd15, 16'h0043); prog(4'd0, 16'hBEEF);

    // bus_pc and bus_mar together: fetch wins; a prog_we mid-transaction is dropped.
    xact(1'b1, 1'b1, 1'b0, 1'b1, 16'h0005, 16'h0, lat, nb, bytes, vio);
    check("rfetch_bytes", bytes, 32'h0000_510A);
    check("rfetch_nb", nb, 2);
    check("rfetch_lat", lat, 5);
    check("rfetch_idle0", vio, 0);
    xact(1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0, lat, nb, bytes, vio);
    check("prog_dropped", bytes, 32'h0000_510A);

    xact(1'b1, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0, lat, nb, bytes, vio);
    check("ifetch_bytes", bytes, 32'h3212_0500);
    check("ifetch_nb", nb, 4);
    check("ifetch_lat", lat, 7);
    check("ifetch_idle0", vio, 0);
    xact(1'b1, 1'b0, 1'b0, 1'b0, 16'h000F, 16'h0, lat, nb, bytes, vio);
    check("mfetch_wrap", bytes, 32'h4300_EFBE);
    check("mfetch_lat", lat, 7);

    xact(1'b0, 1'b0, 1'b1, 1'b0, 16'h0004, 16'h000B, lat, nb, bytes, vio);
    check("store_lat", lat, 5);
    check("store_nb", nb, 0);
    peek(4'd4, d);
    check("store_dbg", {16'h0, d}, 32'h0000_000B);
    xact(1'b0, 1'b0, 1'b0, 1'b0, 16'h0004, 16'h0, lat, nb, bytes, vio);
    check("load_bytes", bytes, 32'h0000_0B00);
    check("load_lat", lat, 5);

`ifdef SMB_RANGE_CHECK_EN
    check("rerr_clear", {31'b0, range_err}, 32'd0);
`endif
    xact(1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0, lat, nb, bytes, vio);
`ifdef SMB_RANGE_CHECK_EN
    check("oor_load", bytes, 32'h0000_FFFF);
    check("rerr_set", {31'b0, range_err}, 32'd1);
`else
    check("wrap_load", bytes, 32'h0000_0000);
`endif
    xact(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 16'hA5C3, lat, nb, bytes, vio);
    peek(4'd0, d);
`ifdef SMB_RANGE_CHECK_EN
    check("oor_store", {16'h0, d}, 32'h0000_0000);
`else
    check("wrap_store", {16'h0, d}, 32'h0000_A5C3);
`endif
    xact(1'b1, 1'b0, 1'b0, 1'b0, 16'h0105, 16'h0, lat, nb, bytes, vio);
`ifdef SMB_RANGE_CHECK_EN
    check("oor_fetch", bytes, 32'h0000_FFFF);
`else
    check("wrap_fetch", bytes, 32'h0000_510A);
`endif
    check("wrap_fetch_lat", lat, 5);

    // Reset during W_HI of a store to index 3 must abort the write.
    bus_mar = 1'b1; out_bus = 8'h03; step();
    bus_mar = 1'b0; bus_mdr = 1'b1; out_bus = 8'h00; step();
    bus_mdr = 1'b0; out_bus = 8'h77; step();
    rst = 1'b0; step();
    check("abort_rr_low", {31'b0, ard_receive_ready}, 32'd0);
    rst = 1'b1; out_bus = 8'h00; step();
    check("abort_rr_high", {31'b0, ard_receive_ready}, 32'd1);
    peek(4'd3, d);
    check("abort_nowrite", {16'h0, d}, 32'h0);
    peek(4'd4, d);
    check("dmem_cleared", {16'h0, d}, 32'h0);

    // Halt: handshakes stay low, bus_pc ignored, prog loads still accepted.
    halt = 1'b1; step();
    halt = 1'b0;
    check("halt_rr", {31'b0, ard_receive_ready}, 32'd0);
    prog(4'd6, 16'h0001);
    busy = 0;
    bus_pc = 1'b1; out_bus = 8'h06;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ard_receive_ready || ard_data_ready) busy++;
    end
    bus_pc = 1'b0; out_bus = 8'h00;
    check("halt_ignore", busy, 0);
    rst = 1'b0; step();
    rst = 1'b1; step();
    check("halt_exit_rr", {31'b0, ard_receive_ready}, 32'd1);
    xact(1'b1, 1'b0, 1'b0, 1'b0, 16'h0006, 16'h0, lat, nb, bytes, vio);
    check("halt_prog", bytes, 32'h0000_0100);
    xact(1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0, lat, nb, bytes, vio);
    check("imem_retained", bytes, 32'h0000_510A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
